// File: rtl/if_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and ROM.
// The fetch side owns the request; the memory answers with ack and data.
interface if_fetch_if;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic        rom_ack;
    logic [31:0] rom_data;

    modport master (output rom_ce, rom_addr, input rom_ack, rom_data);
    modport slave  (input rom_ce, rom_addr, output rom_ack, rom_data);
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC generation, ROM handshake and a registered IF/ID pair.
// One-entry skid buffer absorbs an ack that lands while downstream is stalled.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    if_fetch_if.master  rom,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } slot_t;

    state_t      state_q, state_nx;
    logic [31:0] pc_q, pc_nx;
    logic        redir_pend_q, redir_pend_nx;
    logic [31:0] redir_tgt_q, redir_tgt_nx;
    slot_t       buf_q, buf_nx;
    slot_t       out_q, out_nx;
    logic        valid_q, valid_nx;
    logic        ce_q, ce_nx;
    logic [31:0] addr_q, addr_nx;

    logic        ack_ok;
    logic [31:0] next_pc;

    // An ack only counts while a request is actually outstanding.
    assign ack_ok = (state_q == FETCH) && rom.rom_ack;

    // A same-cycle branch beats an older pending redirect.
    always_comb begin
        next_pc = pc_q + 32'd4;
        if (branch_flag_i)
            next_pc = branch_target_i;
        else if (redir_pend_q)
            next_pc = redir_tgt_q;
    end

    always_comb begin
        state_nx      = state_q;
        pc_nx         = pc_q;
        redir_pend_nx = redir_pend_q;
        redir_tgt_nx  = redir_tgt_q;
        buf_nx        = buf_q;
        out_nx        = out_q;
        valid_nx      = valid_q;
        ce_nx         = ce_q;
        addr_nx       = addr_q;

        // Redirects arriving without an ack wait for the next accepted fetch.
        if (ack_ok) begin
            redir_pend_nx = 1'b0;
        end else if (branch_flag_i) begin
            redir_pend_nx = 1'b1;
            redir_tgt_nx  = branch_target_i;
        end

        case (state_q)
            IDLE: begin
                state_nx = FETCH;
                ce_nx    = 1'b1;
                addr_nx  = pc_q;
            end
            FETCH: begin
                if (!ack_ok) begin
                    if (!stall) begin
                        out_nx   = '0;
                        valid_nx = 1'b0;
                    end
                end else if (!stall) begin
                    out_nx   = '{pc: pc_q, inst: rom.rom_data};
                    valid_nx = 1'b1;
                    pc_nx    = next_pc;
                    addr_nx  = next_pc;
                end else begin
                    buf_nx   = '{pc: pc_q, inst: rom.rom_data};
                    pc_nx    = next_pc;
                    ce_nx    = 1'b0;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (!stall) begin
                    out_nx   = buf_q;
                    valid_nx = 1'b1;
                    ce_nx    = 1'b1;
                    addr_nx  = pc_q;
                    state_nx = FETCH;
                end
            end
            default: begin
                state_nx = IDLE;
                ce_nx    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            redir_pend_q <= 1'b0;
            redir_tgt_q  <= '0;
            buf_q        <= '0;
            out_q        <= '0;
            valid_q      <= 1'b0;
            ce_q         <= 1'b0;
            addr_q       <= '0;
        end else begin
            state_q      <= state_nx;
            pc_q         <= pc_nx;
            redir_pend_q <= redir_pend_nx;
            redir_tgt_q  <= redir_tgt_nx;
            buf_q        <= buf_nx;
            out_q        <= out_nx;
            valid_q      <= valid_nx;
            ce_q         <= ce_nx;
            addr_q       <= addr_nx;
        end
    end

    assign rom.rom_ce   = ce_q;
    assign rom.rom_addr = addr_q;
    assign if_pc        = out_q.pc;
    assign if_inst      = out_q.inst;
    assign if_valid     = valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios plus a randomized run checked against
// a transaction-level model of the fetch stream (address order and delivery).
module tb_if_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        stall;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic [31:0] if_pc, if_inst;
    logic        if_valid;
    logic [31:0] w_pc, w_inst;
    logic        w_valid;

    if_fetch_if bus ();
    if_fetch_if wbus ();

    if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_flag_i(branch_flag_i),
        .branch_target_i(branch_target_i), .rom(bus),
        .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid)
    );

    if_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst), .stall(1'b0), .branch_flag_i(1'b0),
        .branch_target_i(32'h0), .rom(wbus),
        .if_pc(w_pc), .if_inst(w_inst), .if_valid(w_valid)
    );

    // Zero-wait memory for the wrap instance.
    assign wbus.rom_ack  = wbus.rom_ce;
    assign wbus.rom_data = ~wbus.rom_addr;

    a_ack_needs_ce: assert property (@(posedge clk) disable iff (rst) bus.rom_ack |-> bus.rom_ce)
        else $error("protocol violation: rom_ack while rom_ce low");

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] sq[$];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drv(input logic ack_en, input logic st, input logic br, input logic [31:0] tgt);
        stall           = st;
        branch_flag_i   = br;
        branch_target_i = tgt;
        bus.rom_ack     = ack_en && bus.rom_ce;
        bus.rom_data    = bus.rom_ack ? memf(bus.rom_addr) : 32'hDEAD_BEEF;
    endtask

    task automatic do_reset();
        drv(1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drv(1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({bus.rom_ce, bus.rom_addr} !== 33'h0) begin
            n_fail++; $display("FAIL reset_rom got ce=%0b addr=%h want 0/0", bus.rom_ce, bus.rom_addr);
        end
        n_tests++;
        if ({if_valid, if_pc, if_inst} !== 65'h0) begin
            n_fail++; $display("FAIL reset_if got v=%0b pc=%h inst=%h want zeros", if_valid, if_pc, if_inst);
        end
        n_tests++;
        if ({wbus.rom_ce, w_valid} !== 2'b00) begin
            n_fail++; $display("FAIL reset_wrap got ce=%0b v=%0b want 0", wbus.rom_ce, w_valid);
        end
        rst = 1'b0;
    endtask

    task automatic test_zero_wait();
        do_reset();
        tick();
        n_tests++;
        if ({bus.rom_ce, bus.rom_addr, if_valid} !== {1'b1, 32'h0, 1'b0}) begin
            n_fail++; $display("FAIL zw_first_req got ce=%0b addr=%h v=%0b want 1/0/0", bus.rom_ce, bus.rom_addr, if_valid);
        end
        for (int k = 1; k <= 4; k++) begin
            drv(1'b1, 1'b0, 1'b0, 32'h0);
            tick();
            n_tests++;
            if (bus.rom_ce !== 1'b1 || bus.rom_addr !== 32'(4 * k) || if_valid !== 1'b1 ||
                if_pc !== 32'(4 * (k - 1)) || if_inst !== memf(32'(4 * (k - 1)))) begin
                n_fail++;
                $display("FAIL zw_seq[%0d] got addr=%h pc=%h inst=%h v=%0b want addr=%h pc=%h inst=%h v=1",
                         k, bus.rom_addr, if_pc, if_inst, if_valid, 32'(4 * k), 32'(4 * (k - 1)), memf(32'(4 * (k - 1))));
            end
        end
    endtask

    task automatic test_two_cycle();
        logic [31:0] exp_pc;
        exp_pc = 32'h0;
        do_reset();
        tick();
        for (int k = 0; k < 8; k++) begin
            drv(k[0], 1'b0, 1'b0, 32'h0);
            tick();
            n_tests++;
            if (k[0]) begin
                if (if_valid !== 1'b1 || if_pc !== exp_pc || if_inst !== memf(exp_pc)) begin
                    n_fail++; $display("FAIL two_cycle_valid[%0d] got v=%0b pc=%h want v=1 pc=%h", k, if_valid, if_pc, exp_pc);
                end
                exp_pc = exp_pc + 32'd4;
            end else if ({if_valid, if_pc, if_inst} !== 65'h0) begin
                n_fail++; $display("FAIL two_cycle_bubble[%0d] got v=%0b pc=%h inst=%h want zeros", k, if_valid, if_pc, if_inst);
            end
        end
    endtask

    task automatic test_stall_hold();
        do_reset();
        tick();
        drv(1'b1, 1'b0, 1'b0, 32'h0); tick();
        drv(1'b1, 1'b0, 1'b0, 32'h0); tick();
        n_tests++;
        if (bus.rom_addr !== 32'h8) begin
            n_fail++; $display("FAIL hold_setup got addr=%h want 8", bus.rom_addr);
        end
        drv(1'b1, 1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++;
            if (bus.rom_ce !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h4 || if_inst !== memf(32'h4)) begin
                n_fail++; $display("FAIL hold_stalled[%0d] got ce=%0b v=%0b pc=%h want ce=0 v=1 pc=4", k, bus.rom_ce, if_valid, if_pc);
            end
            drv(1'b0, 1'b1, 1'b0, 32'h0);
        end
        drv(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        n_tests++;
        if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_inst !== memf(32'h8) || bus.rom_ce !== 1'b1 || bus.rom_addr !== 32'hC) begin
            n_fail++; $display("FAIL hold_release got v=%0b pc=%h inst=%h ce=%0b addr=%h want 1/8/%h/1/c",
                               if_valid, if_pc, if_inst, bus.rom_ce, bus.rom_addr, memf(32'h8));
        end
    endtask

    task automatic test_branch_wait();
        do_reset();
        tick();
        repeat (5) begin drv(1'b1, 1'b0, 1'b0, 32'h0); tick(); end
        drv(1'b0, 1'b0, 1'b1, 32'h100); tick();
        drv(1'b0, 1'b0, 1'b0, 32'h0); tick();
        n_tests++;
        if (bus.rom_ce !== 1'b1 || bus.rom_addr !== 32'h14) begin
            n_fail++; $display("FAIL br_wait_held got ce=%0b addr=%h want 1/14", bus.rom_ce, bus.rom_addr);
        end
        drv(1'b1, 1'b0, 1'b0, 32'h0); tick();
        n_tests++;
        if (if_valid !== 1'b1 || if_pc !== 32'h14 || bus.rom_addr !== 32'h100) begin
            n_fail++; $display("FAIL br_wait_slot got v=%0b pc=%h addr=%h want 1/14/100", if_valid, if_pc, bus.rom_addr);
        end
        drv(1'b1, 1'b0, 1'b0, 32'h0); tick();
        n_tests++;
        if (if_pc !== 32'h100 || if_inst !== memf(32'h100) || bus.rom_addr !== 32'h104) begin
            n_fail++; $display("FAIL br_wait_target got pc=%h addr=%h want 100/104", if_pc, bus.rom_addr);
        end
    endtask

    task automatic test_branch_coincident();
        do_reset();
        tick();
        repeat (8) begin drv(1'b1, 1'b0, 1'b0, 32'h0); tick(); end
        drv(1'b1, 1'b0, 1'b1, 32'h200); tick();
        n_tests++;
        if (if_valid !== 1'b1 || if_pc !== 32'h20 || bus.rom_addr !== 32'h200) begin
            n_fail++; $display("FAIL br_coinc_slot got v=%0b pc=%h addr=%h want 1/20/200", if_valid, if_pc, bus.rom_addr);
        end
        drv(1'b1, 1'b0, 1'b0, 32'h0); tick();
        n_tests++;
        if (if_pc !== 32'h200 || bus.rom_addr !== 32'h204) begin
            n_fail++; $display("FAIL br_coinc_target got pc=%h addr=%h want 200/204", if_pc, bus.rom_addr);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick();
        repeat (16) begin drv(1'b1, 1'b0, 1'b0, 32'h0); tick(); end
        n_tests++;
        if (bus.rom_ce !== 1'b1 || bus.rom_addr !== 32'h40) begin
            n_fail++; $display("FAIL rst_mid_setup got ce=%0b addr=%h want 1/40", bus.rom_ce, bus.rom_addr);
        end
        drv(1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        tick();
        n_tests++;
        if ({bus.rom_ce, bus.rom_addr, if_valid, if_pc, if_inst} !== 98'h0) begin
            n_fail++; $display("FAIL rst_mid_zero got ce=%0b addr=%h v=%0b pc=%h inst=%h want zeros",
                               bus.rom_ce, bus.rom_addr, if_valid, if_pc, if_inst);
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if (bus.rom_ce !== 1'b1 || bus.rom_addr !== 32'h0) begin
            n_fail++; $display("FAIL rst_mid_restart got ce=%0b addr=%h want 1/0", bus.rom_ce, bus.rom_addr);
        end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        tick();
        n_tests++;
        if (wbus.rom_ce !== 1'b1 || wbus.rom_addr !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL wrap_first got ce=%0b addr=%h want 1/fffffffc", wbus.rom_ce, wbus.rom_addr);
        end
        tick();
        n_tests++;
        if (wbus.rom_addr !== 32'h0 || w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFFC || w_inst !== 32'h3) begin
            n_fail++; $display("FAIL wrap_next got addr=%h v=%0b pc=%h inst=%h want 0/1/fffffffc/3", wbus.rom_addr, w_valid, w_pc, w_inst);
        end
        tick();
        n_tests++;
        if (wbus.rom_addr !== 32'h4 || w_pc !== 32'h0) begin
            n_fail++; $display("FAIL wrap_after got addr=%h pc=%h want 4/0", wbus.rom_addr, w_pc);
        end
    endtask

    // Model: ordered stream of accepted fetches, next-address rule, and
    // "at most one instruction parked behind the displayed one".
    task automatic test_random();
        logic [31:0] exp_addr, ptgt, tgt, p_addr, p_pc, p_inst;
        logic        pend, st, br, ackr, acc, p_ce, p_v;
        exp_addr = 32'h0;
        pend     = 1'b0;
        ptgt     = 32'h0;
        sq.delete();
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            p_ce = bus.rom_ce; p_addr = bus.rom_addr;
            p_v = if_valid; p_pc = if_pc; p_inst = if_inst;
            st   = ($urandom % 100) < 30;
            br   = ($urandom % 100) < 12;
            tgt  = $urandom;
            ackr = ($urandom % 100) < 60;
            drv(ackr, st, br, tgt);
            acc = bus.rom_ack;

            if (p_v) begin
                n_tests++;
                if (sq.size() == 0 || {p_pc, p_inst} !== sq[0]) begin
                    n_fail++; $display("FAIL rnd_order[%0d] got pc=%h inst=%h want queued head (size %0d)", cyc, p_pc, p_inst, sq.size());
                end
                if (!st && sq.size() != 0) void'(sq.pop_front());
            end
            if (acc) begin
                n_tests++;
                if (p_addr !== exp_addr) begin
                    n_fail++; $display("FAIL rnd_fetch_addr[%0d] got %h want %h", cyc, p_addr, exp_addr);
                end
                sq.push_back({p_addr, memf(p_addr)});
                exp_addr = br ? tgt : (pend ? ptgt : p_addr + 32'd4);
                pend = 1'b0;
            end else if (br) begin
                pend = 1'b1;
                ptgt = tgt;
            end

            tick();

            n_tests++;
            if (sq.size() > 2) begin
                n_fail++; $display("FAIL rnd_overbuffer[%0d] got %0d pending want <=2", cyc, sq.size());
            end
            n_tests++;
            if (st) begin
                if ({if_valid, if_pc, if_inst} !== {p_v, p_pc, p_inst}) begin
                    n_fail++; $display("FAIL rnd_stall_hold[%0d] got v=%0b pc=%h want v=%0b pc=%h", cyc, if_valid, if_pc, p_v, p_pc);
                end
            end else if (sq.size() != 0) begin
                if (if_valid !== 1'b1 || {if_pc, if_inst} !== sq[0]) begin
                    n_fail++; $display("FAIL rnd_deliver[%0d] got v=%0b pc=%h want v=1 pc=%h", cyc, if_valid, if_pc, sq[0][63:32]);
                end
            end else if ({if_valid, if_pc, if_inst} !== 65'h0) begin
                n_fail++; $display("FAIL rnd_bubble[%0d] got v=%0b pc=%h inst=%h want zeros", cyc, if_valid, if_pc, if_inst);
            end

            if (acc && st) begin
                n_tests++;
                if (bus.rom_ce !== 1'b0) begin
                    n_fail++; $display("FAIL rnd_park_ce[%0d] got ce=%0b want 0", cyc, bus.rom_ce);
                end
            end else if ((acc && !st) || (!p_ce && !st)) begin
                n_tests++;
                if (bus.rom_ce !== 1'b1 || bus.rom_addr !== exp_addr) begin
                    n_fail++; $display("FAIL rnd_next_req[%0d] got ce=%0b addr=%h want 1/%h", cyc, bus.rom_ce, bus.rom_addr, exp_addr);
                end
            end else if (p_ce && !acc) begin
                n_tests++;
                if (bus.rom_ce !== 1'b1 || bus.rom_addr !== p_addr) begin
                    n_fail++; $display("FAIL rnd_req_stable[%0d] got ce=%0b addr=%h want 1/%h", cyc, bus.rom_ce, bus.rom_addr, p_addr);
                end
            end
        end
    endtask

    initial begin
        rst             = 1'b1;
        stall           = 1'b0;
        branch_flag_i   = 1'b0;
        branch_target_i = 32'h0;
        bus.rom_ack     = 1'b0;
        bus.rom_data    = 32'h0;
        @(negedge clk);
        test_reset();
        test_zero_wait();
        test_two_cycle();
        test_stall_hold();
        test_branch_wait();
        test_branch_coincident();
        test_reset_mid();
        test_pc_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
